// File: rtl/cosim_ctrl_pkg.sv
// Shared types and constants for the cosim run-control sequencer.
//   state_e      : sequencer state (SEQ -> RUN -> DRAIN -> DONE/FAIL)
//   fatal_code_e : cause reported alongside fatal
//   WD_CONTINUE / WD_DONE : watchdog status encodings; any other value is an error
package cosim_ctrl_pkg;

  typedef enum logic [2:0] {
    SEQ,
    RUN,
    DRAIN,
    DONE,
    FAIL
  } state_e;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    WD_ERR    = 2'd1,
    COMMIT_TO = 2'd2,
    DUMP_END  = 2'd3
  } fatal_code_e;

  localparam logic [7:0] WD_CONTINUE = 8'h00;
  localparam logic [7:0] WD_DONE     = 8'hFF;

  function automatic logic is_terminal(state_e s);
    return (s == DONE) || (s == FAIL);
  endfunction

endpackage

// File: rtl/commit_interval_timer.sv
// Commit-interval timer: counts cycles elapsed since the last commit.
//   clock, reset : clock, synchronous active-high reset
//   clear        : this cycle counts as elapsed 0 (commit seen, or pre-run)
//   enable       : timer advances this cycle (sequencer in RUN)
//   timeout      : max elapsed cycles allowed; 0 disables
//   expired      : elapsed count equals timeout this cycle
module commit_interval_timer #(
  parameter int TIMEOUT_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] timeout,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] timer_q, timer_d, timer_eff;

  // A clear takes effect in its own cycle, so a commit cycle reads as
  // elapsed 0 and can never expire; the following cycle reads as 1.
  always_comb begin
    timer_eff = clear ? '0 : timer_q;
    timer_d   = enable ? timer_eff + TIMEOUT_W'(1) : timer_eff;
    expired   = enable && (timeout != '0) && (timer_eff == timeout);
  end

  always_ff @(posedge clock) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end

endmodule

// File: rtl/cosim_run_ctrl.sv
// Run-control sequencer for the cosim top: DUT reset/init sequencing,
// cycle counting, watchdog evaluation, commit timeout, dump window and a
// single sticky finish/fatal decision.
//   clock, reset          : sole clock, synchronous active-high reset
//   wd_valid, wd_status   : per-cycle watchdog result (0 go, 255 done, else error)
//   idle                  : DUT idle
//   commit                : instruction-commit pulse
//   timeout               : max cycles between commits (0 disables)
//   dump_start, dump_end  : dump enable cycle / abort cycle (end 0 disables)
//   dut_reset, init_flag  : derived from the cycle count
//   dump_en               : sticky dump window flag
//   cycle                 : cycle count, frozen once DONE/FAIL
//   finish, fatal         : sticky decisions; fatal_code gives the cause
module cosim_run_ctrl
  import cosim_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 5,
  parameter int INIT_CYCLES  = 1,
  parameter int CYCLE_W      = 64,
  parameter int TIMEOUT_W    = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wd_valid,
  input  logic [7:0]           wd_status,
  input  logic                 idle,
  input  logic                 commit,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic [CYCLE_W-1:0]   dump_start,
  input  logic [CYCLE_W-1:0]   dump_end,
  output logic                 dut_reset,
  output logic                 init_flag,
  output logic                 dump_en,
  output logic [CYCLE_W-1:0]   cycle,
  output logic                 finish,
  output logic                 fatal,
  output logic [1:0]           fatal_code
);

  if (INIT_CYCLES > RESET_CYCLES) begin : g_bad_params
    $error("cosim_run_ctrl: INIT_CYCLES must not exceed RESET_CYCLES");
  end

  state_e             state_q, state_d;
  fatal_code_e        fatal_code_q, fatal_code_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic               dump_en_q, dump_en_d;
  logic               finish_q, finish_d;
  logic               fatal_q, fatal_d;

  logic wd_err, wd_done, end_hit, tmr_clear, tmr_en, tmr_expired;

  // Timer is held at zero until RUN so it starts cleared on RUN entry,
  // and is frozen (neither cleared nor advanced) in DRAIN and beyond.
  assign tmr_clear = (state_q == SEQ) || ((state_q == RUN) && commit);
  assign tmr_en    = (state_q == RUN);

  commit_interval_timer #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .timeout(timeout),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    fatal_code_d = fatal_code_q;
    cycle_d      = cycle_q;
    dump_en_d    = dump_en_q;
    finish_d     = finish_q;
    fatal_d      = fatal_q;

    wd_err  = wd_valid && (wd_status != WD_CONTINUE) && (wd_status != WD_DONE);
    wd_done = wd_valid && (wd_status == WD_DONE);
    end_hit = (dump_end != '0) && (cycle_q == dump_end);

    // Branch order encodes same-cycle priority: wd error, commit timeout,
    // dump end, then normal completion.
    case (state_q)
      SEQ: begin
        if (cycle_q == CYCLE_W'(RESET_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        if (wd_err) begin
          state_d = FAIL; fatal_code_d = WD_ERR;
        end else if (tmr_expired) begin
          state_d = FAIL; fatal_code_d = COMMIT_TO;
        end else if (end_hit) begin
          state_d = FAIL; fatal_code_d = DUMP_END;
        end else if (wd_done) begin
          state_d = idle ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (wd_err) begin
          state_d = FAIL; fatal_code_d = WD_ERR;
        end else if (end_hit) begin
          state_d = FAIL; fatal_code_d = DUMP_END;
        end else if (idle) begin
          state_d = DONE;
        end
      end
      default: ;
    endcase

    if (!is_terminal(state_q)) begin
      cycle_d = cycle_q + CYCLE_W'(1);
      if (cycle_q == dump_start) dump_en_d = 1'b1;
    end

    // Decisions land on the same edge the state does.
    if (state_d == DONE) finish_d = 1'b1;
    if (state_d == FAIL) fatal_d  = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SEQ;
      fatal_code_q <= NONE;
      cycle_q      <= '0;
      dump_en_q    <= 1'b0;
      finish_q     <= 1'b0;
      fatal_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fatal_code_q <= fatal_code_d;
      cycle_q      <= cycle_d;
      dump_en_q    <= dump_en_d;
      finish_q     <= finish_d;
      fatal_q      <= fatal_d;
    end
  end

  assign init_flag  = (cycle_q < CYCLE_W'(INIT_CYCLES));
  assign dut_reset  = (cycle_q < CYCLE_W'(RESET_CYCLES));
  assign dump_en    = dump_en_q;
  assign cycle      = cycle_q;
  assign finish     = finish_q;
  assign fatal      = fatal_q;
  assign fatal_code = fatal_code_q;

endmodule
